// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 2-flop RX synchronizer, start/data/stop bit
// sequencer with mid-bit sampling, and a small receive FIFO drained over a
// VALID/READY handshake. Frame format is 8N1, LSB first, idle-high line.
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 200,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   input  logic       i_en,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   // synchronizer, FSM and datapath registers
   logic          r_sync1, r_sync2;
   state_t        r_state, w_state_nxt;
   logic [TW-1:0] r_timer, w_timer_nxt;
   logic [2:0]    r_idx,   w_idx_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic          w_push, w_ferr;
   logic          r_ferr, r_ovr;

   // FIFO storage and bookkeeping
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_rx_s, w_full, w_pop, w_wr_en;

   assign w_rx_s  = r_sync2;
   assign w_full  = (r_count == CNT_FULL);
   assign w_pop   = o_valid & i_ready;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign w_wr_en = w_push & (~w_full | w_pop);

   // two-flop synchronizer for the asynchronous line; idles high
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
      end
   end

   // FSM state, bit timer, bit index and shift register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   // next-state: half-bit wait to centre on the start bit, then whole-bit steps
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_push      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_en && !w_rx_s) begin
               w_state_nxt = S_START;
               w_timer_nxt = '0;
            end
         end
         S_START: begin
            if (r_timer == HALF_M1) begin
               w_timer_nxt = '0;
               w_idx_nxt   = '0;
               w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_DATA: begin
            if (r_timer == FULL_M1) begin
               w_timer_nxt          = '0;
               w_shift_nxt[r_idx]   = w_rx_s;
               if (r_idx == 3'd7) w_state_nxt = S_STOP;
               else               w_idx_nxt   = r_idx + 1'b1;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_STOP: begin
            if (r_timer == FULL_M1) begin
               w_timer_nxt = '0;
               if (w_rx_s) begin
                  w_push      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_BREAK: begin
            // a line held low must return high before a new start is seen
            if (w_rx_s) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FIFO pointers, occupancy and the registered error pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ferr   <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_ferr <= w_ferr;
         r_ovr  <= w_push & w_full & ~w_pop;
      end
   end

   // FIFO storage; contents are never observed while empty, so no reset
   always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
   end

   assign o_valid     = (r_count != '0);
   assign o_data      = o_valid ? r_mem[r_rd_ptr] : 8'h00;
   assign o_frame_err = r_ferr;
   assign o_overrun   = r_ovr;
   assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (CLKS_PER_BIT=16, FIFO_DEPTH=4). Good
// frames push their expected byte into a queue; a negedge monitor pops and
// compares whenever the DUT hands a byte over.
module tb_uart_rx_ctrl;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       en = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid, ferr, ovr, busy;

   int checks = 0;
   int errors = 0;
   int pops = 0, vcyc = 0, ferr_n = 0, ovr_n = 0, busy_n = 0;
   int p0, v0, f0, o0, b0;
   logic [7:0] exp_q[$];

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_en(en),
      .o_data(data), .o_valid(valid), .i_ready(ready),
      .o_frame_err(ferr), .o_overrun(ovr), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // one tick per iteration: start, 8 data bits LSB first, stop bit.
   // rdy_at raises READY for exactly one cycle; abort_at returns early.
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input int rdy_at, input int abort_at);
      for (int t = 0; t < 10 * CPB; t++) begin
         int b;
         b = t / CPB;
         if (t == abort_at) return;
         if (b == 0)      rx = 1'b0;
         else if (b <= 8) rx = d[b-1];
         else             rx = stop;
         if (t == rdy_at) ready = 1'b1;
         if (rdy_at >= 0 && t == rdy_at + 1) ready = 1'b0;
         tick();
      end
   endtask

   // handshake monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (valid) vcyc++;
         if (ferr)  ferr_n++;
         if (ovr)   ovr_n++;
         if (busy)  busy_n++;
         if (valid && ready) begin
            pops++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_pop: observed %0h expected no byte", data);
            end else begin
               check("pop_data", data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      // reset state
      rst = 1'b1;
      ticks(3);
      check("rst_data",  data,  8'h00);
      check("rst_valid", valid, 1'b0);
      check("rst_ferr",  ferr,  1'b0);
      check("rst_ovr",   ovr,   1'b0);
      check("rst_busy",  busy,  1'b0);
      rst = 1'b0;
      ready = 1'b1;
      ticks(5);

      // 1: good frame 0xA5 with READY held high
      v0 = vcyc; f0 = ferr_n; o0 = ovr_n; p0 = pops;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, -1, -1);
      ticks(20);
      check("t1_valid_cycles", vcyc - v0, 1);
      check("t1_pops",         pops - p0, 1);
      check("t1_ferr",         ferr_n - f0, 0);
      check("t1_ovr",          ovr_n - o0, 0);
      check("t1_busy",         busy, 1'b0);

      // 2: 4-cycle glitch aborts at half-bit
      v0 = vcyc; f0 = ferr_n;
      rx = 1'b0;
      ticks(4);
      rx = 1'b1;
      tick();
      check("t2_busy_start", busy, 1'b1);
      ticks(20);
      check("t2_busy_idle", busy, 1'b0);
      check("t2_valid",     vcyc - v0, 0);
      check("t2_ferr",      ferr_n - f0, 0);

      // 3: framing error, held break, then a good frame
      f0 = ferr_n; p0 = pops;
      send_frame(8'h3C, 1'b0, -1, -1);
      ticks(3 * CPB);
      rx = 1'b1;
      ticks(20);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, -1, -1);
      ticks(20);
      check("t3_ferr_pulses", ferr_n - f0, 1);
      check("t3_pops",        pops - p0, 1);
      check("t3_q_empty",     exp_q.size(), 0);

      // 4: fill with READY low, fifth byte overruns, then drain
      ready = 1'b0;
      o0 = ovr_n; p0 = pops;
      for (int i = 1; i <= 5; i++) begin
         if (i <= DEPTH) exp_q.push_back(8'(i));
         send_frame(8'(i), 1'b1, -1, -1);
      end
      ticks(5);
      check("t4_valid",  valid, 1'b1);
      check("t4_head",   data, 8'h01);
      check("t4_ovr",    ovr_n - o0, 1);
      ready = 1'b1;
      ticks(10);
      check("t4_pops",    pops - p0, 4);
      check("t4_q_empty", exp_q.size(), 0);
      check("t4_valid_end", valid, 1'b0);

      // 5: reset during data bit 3, then a clean frame
      send_frame(8'h55, 1'b1, -1, 4 * CPB + 6);
      check("t5_busy_pre", busy, 1'b1);
      rst = 1'b1;
      tick();
      check("t5_busy",  busy,  1'b0);
      check("t5_valid", valid, 1'b0);
      check("t5_data",  data,  8'h00);
      check("t5_ferr",  ferr,  1'b0);
      check("t5_ovr",   ovr,   1'b0);
      rst = 1'b0;
      rx = 1'b1;
      ticks(20);
      p0 = pops;
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, -1, -1);
      ticks(20);
      check("t5_pops",    pops - p0, 1);
      check("t5_q_empty", exp_q.size(), 0);

      // 6: full FIFO, one-cycle READY aligned with the stop-bit sample
      ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(8'h10 + 8'(i));
         send_frame(8'h10 + 8'(i), 1'b1, -1, -1);
      end
      exp_q.push_back(8'h77);
      o0 = ovr_n; p0 = pops;
      // stop sample lands on the edge after tick 154 of the frame
      send_frame(8'h77, 1'b1, 154, -1);
      ticks(5);
      check("t6_ovr",  ovr_n - o0, 0);
      check("t6_pops", pops - p0, 1);
      check("t6_head", data, 8'h11);
      ready = 1'b1;
      ticks(10);
      check("t6_pops_all", pops - p0, 5);
      check("t6_q_empty",  exp_q.size(), 0);

      // 7: EN low ignores a frame; EN high later receives the next one
      en = 1'b0;
      b0 = busy_n; v0 = vcyc;
      send_frame(8'h5A, 1'b1, -1, -1);
      ticks(20);
      check("t7_busy",  busy_n - b0, 0);
      check("t7_valid", vcyc - v0, 0);
      en = 1'b1;
      ticks(10);
      p0 = pops;
      exp_q.push_back(8'h99);
      send_frame(8'h99, 1'b1, -1, -1);
      ticks(20);
      check("t7_pops",    pops - p0, 1);
      check("t7_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
